// File: rtl/data_bus_responder_pkg.sv
// Shared constants and helpers for the CPU data-bus responder.
// The config page sits at one 64 KiB window; offsets below are within it.
package data_bus_responder_pkg;

  localparam logic [15:0] CONF_BASE_HI = 16'hbfaf;

  localparam logic [15:0] LED_OFF = 16'hf000;
  localparam logic [15:0] SCR_OFF = 16'hf010;
  localparam logic [15:0] SW_OFF  = 16'hf020;
  localparam logic [15:0] TMR_OFF = 16'he000;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_CONF
  } rd_src_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_bus_responder_data_ram_bank.sv
// Word-wide data RAM with per-byte write enables and a registered read port.
// Storage and read register are not reset; the read register only loads on re.
module data_ram_bank #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_bus_responder.sv
// Responder for the CPU data SRAM port: word RAM plus a small config page
// (LED, scratch, switches, free-running timer) with one-cycle read latency.
module data_bus_responder #(
  parameter int          RAM_AW       = 12,
  parameter logic [15:0] CONF_BASE_HI = data_bus_responder_pkg::CONF_BASE_HI,
  parameter int          LED_W        = 16,
  parameter int          SW_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic             timer_wrap
);
  import data_bus_responder_pkg::*;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      timer_q, timer_d;
  logic             timer_wrap_q, timer_wrap_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
  rd_src_e          rd_src_q, rd_src_d;
  logic [31:0]      conf_rdata_q, conf_rdata_d;

  logic        conf_sel, rd_req, wr_req, tmr_wr;
  logic [15:0] conf_off;
  logic [31:0] conf_rd;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic        addr_unused;

  assign addr_unused = ^data_sram_addr[1:0];

  always_comb begin
    conf_sel = (data_sram_addr[31:16] == CONF_BASE_HI);
    conf_off = data_sram_addr[15:0];
    rd_req   = data_sram_en && (data_sram_wen == 4'h0);
    wr_req   = data_sram_en && (data_sram_wen != 4'h0);

    case (conf_off)
      LED_OFF: conf_rd = 32'(led_q);
      SCR_OFF: conf_rd = scratch_q;
      SW_OFF:  conf_rd = 32'(sw_sync_q);
      TMR_OFF: conf_rd = timer_q;
      default: conf_rd = 32'h0;
    endcase

    led_d     = led_q;
    scratch_d = scratch_q;
    tmr_wr    = 1'b0;
    if (wr_req && conf_sel) begin
      case (conf_off)
        LED_OFF: led_d = LED_W'(byte_merge(32'(led_q), data_sram_wdata,
                                           data_sram_wen & 4'b0011));
        SCR_OFF: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
        TMR_OFF: tmr_wr = 1'b1;
        default: ;
      endcase
    end

    // A timer write replaces this cycle's increment and suppresses the wrap pulse.
    timer_d      = tmr_wr ? byte_merge(timer_q, data_sram_wdata, data_sram_wen)
                          : timer_q + 32'd1;
    timer_wrap_d = (timer_q == 32'hffff_ffff) && !tmr_wr;

    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;

    rd_src_d     = rd_src_q;
    conf_rdata_d = conf_rdata_q;
    if (rd_req) begin
      rd_src_d = conf_sel ? SRC_CONF : SRC_RAM;
      if (conf_sel) conf_rdata_d = conf_rd;
    end
  end

  // Gating with resetn drops a RAM write whose edge coincides with reset.
  assign ram_re = rd_req && !conf_sel;
  assign ram_we = {4{wr_req && !conf_sel && resetn}} & data_sram_wen;

  data_ram_bank #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= '0;
      scratch_q    <= '0;
      timer_q      <= '0;
      timer_wrap_q <= 1'b0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      rd_src_q     <= SRC_NONE;
      conf_rdata_q <= '0;
    end else begin
      led_q        <= led_d;
      scratch_q    <= scratch_d;
      timer_q      <= timer_d;
      timer_wrap_q <= timer_wrap_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      rd_src_q     <= rd_src_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  // conf_rdata_q is zero until the first config read, which covers SRC_NONE.
  assign data_sram_rdata = (rd_src_q == SRC_RAM) ? ram_rdata : conf_rdata_q;
  assign led             = led_q;
  assign timer_wrap      = timer_wrap_q;

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Responder end of the CPU data SRAM interface (en/wen/addr/wdata/rdata). It serves word-addressed data RAM plus a small memory-mapped config register page (LED, switches, free-running timer, scratch). Sits outside the CPU core, wired directly to the core's data_sram_* outputs and its rdata input. It fixes the one-cycle read latency the pipeline's memory stage depends on.

Parameters:
RAM_AW, 12, RAM word-address width; depth = 2^RAM_AW words
CONF_BASE_HI, 16'hbfaf, addr[31:16] value selecting the config page
LED_W, 16, width of led output
SW_W, 8, width of switch input

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
data_sram_en  in  1  access request this cycle
data_sram_wen  in  4  byte write enables; 0 = read
data_sram_addr  in  32  byte address; bits [1:0] ignored
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  read data, one cycle after the request
led  out  LED_W  LED register value
switch  in  SW_W  asynchronous switch inputs
timer_wrap  out  1  one-cycle pulse when timer wraps 0xffffffff->0

Behaviour:
- Single clock clk; reset asynchronous, active-low on resetn. All flops clear on resetn low, except RAM storage, which is not reset.
- Reset values: data_sram_rdata=0, led=0, timer=0, scratch=0, timer_wrap=0, switch sync flops=0.
- Decode: conf_sel = (addr[31:16]==CONF_BASE_HI). Otherwise RAM, index = addr[RAM_AW+1:2]; higher bits alias.
- Config page offsets (addr[15:0]):
  - 0xf000 LED, RW, low LED_W bits.
  - 0xf010 scratch, RW, 32b.
  - 0xf020 switch, RO, zero-extended.
  - 0xe000 timer, RW.
  - Other offsets read 0; writes to them are dropped.
- Read (en=1, wen=0): data_sram_rdata updates at the next posedge. Latency is exactly 1 cycle, no stall, no backpressure.
- Write (en=1, wen!=0): byte lane i is written iff wen[i]. Applies to RAM and to RW registers; LED honours lanes 0-1 only. A write cycle does not change data_sram_rdata.
- Idle (en=0): data_sram_rdata holds its last value.
- Read-after-write: a read in the cycle immediately after a write to the same address returns the new data.
- Timer:
  - Increments by 1 every cycle.
  - A write to the timer in a cycle wins over the increment; the written bytes merge into the current value, and incrementing resumes the next cycle.
  - Wrap 0xffffffff->0 pulses timer_wrap high for exactly one cycle; no pulse when a write lands on that cycle.
  - A timer read returns the value sampled at the request edge.
- Switch: double-flop synchroniser. A read returns the synchronised value, so a change is visible 2 cycles after it occurs.
- Reset mid-operation: an in-flight read result is discarded and rdata goes to 0. A write whose clock edge coincides with reset assertion is lost.

Decomposition:
- Shared package:
  - CONF_BASE_HI.
  - Offset constants LED_OFF=16'hf000, SCR_OFF=16'hf010, SW_OFF=16'hf020, TMR_OFF=16'he000.
  - Byte-merge function (old, new, wen) -> 32b.
- One sub-module: data_ram_bank.
  - Synchronous-read, byte-write RAM, depth 2^RAM_AW, no reset.
  - Read-enable gated so rdata holds.
- Top module: decode, config registers, timer, synchroniser, output mux registered on the RAM read timing.

Test Plan:
- RAM word: write 0x12345678 to 0x00000100 with wen=4'hf, then read 0x100 -> rdata=0x12345678 one cycle after the request; holds while en=0.
- Byte lanes: write 0xaabbccdd to 0x104, then 0x000000ee with wen=4'b0001, then read -> 0xaabbccee.
- LED/scratch: write 0xdeadbeef to 0xbfaff000 -> led=16'hbeef. Read 0xbfaff000 -> 0x0000beef. Write/read scratch at 0xbfaff010 -> 0xdeadbeef. Read 0xbfaff0f0 -> 0.
- Timer:
  - Write 0xfffffffe to 0xbfafe000; expect timer_wrap pulse exactly 2 cycles later, 1 cycle wide.
  - Write 0xffffffff on a cycle the timer would otherwise wrap -> no pulse that cycle.
- Switch: set switch=8'h5a; read 0xbfaff020 issued 2 cycles later -> 0x0000005a; a read issued 1 cycle after the change returns the old value.
- Reset: assert resetn low between a read request and the following edge -> rdata=0, led=0, timer restarts from 0; RAM at 0x100 still reads 0x12345678 after release.
